run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side initiator for the processor's Start/Ack run handshake; it drives the side of that handshake that the processor top level answers. It preloads a block of words into the processor's data memory through a dedicated write port, then asserts Start and waits for Ack. It counts the execution cycles with the same rule as the processor's internal cycle counter, and reports completion or timeout to the host. It sits between the test/host interface and the processor top level, one instance per processor.

## Interface
- AW, 8: data-memory address width.
- DW, 8: data word width.
- START_CYC, 2: number of cycles Start is held high (≥1).
- MAX_CYC, 16'hFFFF: timeout limit on the run cycle count.

- Clk  in  1  clock; all logic on posedge.
- Reset  in  1  synchronous, active-high; returns the block to IDLE.
- Go  in  1  host request to begin a run; sampled only in IDLE.
- PreloadLen  in  AW  number of words to preload; latched when Go is accepted. 0 skips preload.
- InData  in  DW  preload word stream.
- InValid  in  1  InData valid.
- InReady  out  1  block accepts InData this cycle.
- MemWrEn  out  1  data-memory write strobe to the processor memory.
- MemAddr  out  AW  write address.
- MemWrData  out  DW  write data.
- Start  out  1  to processor Start.
- Ack  in  1  from processor Ack (combinational there; registered use only here).
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- TimedOut  out  1  last run ended by timeout.
- Cycles  out  16  cycle count of the last or current run.

## Operation
- States: IDLE, LOAD, START, RUN, DONE. Encoding is free.
- IDLE:
  - Go=1 latches PreloadLen into len, clears Cycles, TimedOut and the word counter wc.
  - Next state is LOAD if PreloadLen≠0, else START.
  - Go in any other state is ignored.
- LOAD:
  - InReady=1.
  - Each cycle with InValid=1: MemWrEn=1, MemAddr=wc, MemWrData=InData, then wc++.
  - When the accepted word is number len (wc==len-1 at transfer), go to START.
  - InValid=0 stalls with no write. No timeout in LOAD.
- START:
  - Start=1 for exactly START_CYC cycles, counted by a separate counter. Then go to RUN.
  - Ack is ignored in START.
- RUN:
  - Start=0.
  - Each cycle: if Ack=1, go to DONE with no increment.
  - Else if Cycles==MAX_CYC, set TimedOut=1 and go to DONE.
  - Else Cycles++.
  - Cycles therefore equals the number of RUN cycles with Ack low, matching the processor's own counter.
- DONE: Done=1 for one cycle, then IDLE.
- Cycles and TimedOut hold their values in IDLE until the next accepted Go.
- MemAddr/MemWrData are don't-care when MemWrEn=0, but are driven to 0 outside LOAD.
- Width rules:
  - wc is AW bits and does not wrap, because len ≤ 2^AW-1.
  - Cycles is 16 bits and never wraps; the timeout check comes first.
- Reset, including mid-run:
  - Next cycle the state is IDLE.
  - Start, MemWrEn, InReady, Done, Busy, TimedOut = 0; Cycles = 0; wc = 0.
  - Partially preloaded memory is not cleaned up.

## Timing
- All outputs are registered or decoded from the registered state only. There is no combinational path from InValid/Ack to any output.
- Go accepted on edge N: Busy=1 from cycle N+1. LOAD or START is the state in cycle N+1.
- LOAD: one word per cycle at full rate. A burst of len words takes len cycles with InValid held high.
- Start is high in cycles S..S+START_CYC-1. RUN begins in cycle S+START_CYC.
- Ack first seen high in RUN cycle R: DONE is in cycle R+1, with Done=1 and Busy=1. IDLE is in cycle R+2 with Busy=0.
- A Go sampled in the IDLE cycle right after DONE is accepted. Back-to-back runs are legal.
- Simultaneous Reset and Go: Reset wins.
- Ack high on the very first RUN cycle gives Cycles=0, TimedOut=0.

## Test plan
- Reset and idle:
  - Stimulus: Reset held 2 cycles, then released; Go=0 for 5 cycles.
  - Response: every output is 0 throughout.
- Preload 4 words, then run:
  - Stimulus: PreloadLen=4, data 8'h11,8'h22,8'h33,8'h44 with InValid continuous; Ack raised on the 10th RUN cycle.
  - Response: writes go to addresses 0..3 in 4 consecutive cycles. Start is high for 2 cycles. Cycles=9, Done pulses once, TimedOut=0.
- Stalled preload:
  - Stimulus: PreloadLen=3 with InValid pattern 1,0,0,1,1.
  - Response: exactly 3 writes to addresses 0,1,2, and MemWrEn=0 on the stall cycles. START follows the third write.
- Skip preload, immediate Ack:
  - Stimulus: PreloadLen=0, Ack=1 throughout.
  - Response: no MemWrEn. Start is high 2 cycles. Cycles=0, and Done occurs 1 cycle after RUN entry.
- Timeout:
  - Stimulus: MAX_CYC=16'd20 and Ack never rises.
  - Response: Cycles=20, TimedOut=1, Done pulses once, block returns to IDLE.
  - Follow-up: a new Go clears TimedOut and Cycles.
- Reset mid-run and Go while busy:
  - Stimulus: pulse Go during RUN, then assert Reset during RUN at Cycles=5.
  - Response: the extra Go has no effect. After reset, Start=0, Busy=0, Cycles=0 on the next cycle, and no Done pulse occurs.

Source files
------------

// File: rtl/run_sequencer.sv
// Host-side Start/Ack run initiator: preloads processor data memory, pulses Start,
// then counts Ack-low run cycles until Ack or timeout and reports completion.
module run_sequencer #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned START_CYC = 2,
    parameter logic [15:0] MAX_CYC   = 16'hFFFF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic [AW-1:0] PreloadLen,
    input  logic [DW-1:0] InData,
    input  logic          InValid,
    output logic          InReady,
    output logic          MemWrEn,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWrData,
    output logic          Start,
    input  logic          Ack,
    output logic          Busy,
    output logic          Done,
    output logic          TimedOut,
    output logic [15:0]   Cycles
);

    localparam int unsigned    SCW       = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam logic [SCW-1:0] StartLast = SCW'(START_CYC - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StRun, StDone} state_e;

    state_e         stateQ, stateD;
    logic [AW-1:0]  lenQ;
    logic [AW-1:0]  wcQ;
    logic [SCW-1:0] startCntQ;
    logic [15:0]    cyclesQ;
    logic           timedOutQ;
    logic           memWrEnQ;
    logic [AW-1:0]  memAddrQ;
    logic [DW-1:0]  memWrDataQ;

    logic goAccept;
    logic loadXfer;
    logic loadLast;
    logic startLast;
    logic runLimit;

    assign goAccept  = (stateQ == StIdle) && Go;
    assign loadXfer  = (stateQ == StLoad) && InValid;
    assign loadLast  = loadXfer && (wcQ == (lenQ - AW'(1)));
    assign startLast = (stateQ == StStart) && (startCntQ == StartLast);
    assign runLimit  = (cyclesQ == MAX_CYC);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (Go) begin
                    stateD = (PreloadLen != '0) ? StLoad : StStart;
                end
            end
            StLoad: begin
                if (loadLast) begin
                    stateD = StStart;
                end
            end
            StStart: begin
                if (startLast) begin
                    stateD = StRun;
                end
            end
            StRun: begin
                if (Ack || runLimit) begin
                    stateD = StDone;
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        InReady   = (stateQ == StLoad);
        Start     = (stateQ == StStart);
        Busy      = (stateQ != StIdle);
        Done      = (stateQ == StDone);
        MemWrEn   = memWrEnQ;
        MemAddr   = memAddrQ;
        MemWrData = memWrDataQ;
        TimedOut  = timedOutQ;
        Cycles    = cyclesQ;
    end

    // Memory writes are registered so InValid never reaches an output combinationally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lenQ       <= '0;
            wcQ        <= '0;
            startCntQ  <= '0;
            cyclesQ    <= '0;
            timedOutQ  <= 1'b0;
            memWrEnQ   <= 1'b0;
            memAddrQ   <= '0;
            memWrDataQ <= '0;
        end else begin
            memWrEnQ   <= loadXfer;
            memAddrQ   <= loadXfer ? wcQ : '0;
            memWrDataQ <= loadXfer ? InData : '0;

            if (goAccept) begin
                lenQ      <= PreloadLen;
                wcQ       <= '0;
                cyclesQ   <= '0;
                timedOutQ <= 1'b0;
            end

            if (loadXfer) begin
                wcQ <= wcQ + AW'(1);
            end

            if ((stateQ == StStart) && !startLast) begin
                startCntQ <= startCntQ + SCW'(1);
            end else begin
                startCntQ <= '0;
            end

            // Ack wins over the limit; the limit check comes before the increment.
            if ((stateQ == StRun) && !Ack) begin
                if (runLimit) begin
                    timedOutQ <= 1'b1;
                end else begin
                    cyclesQ <= cyclesQ + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized self-checking bench for run_sequencer against a transaction-level model
// of preload writes, Start length, run-cycle count and timeout.
module tb_run_sequencer;

    localparam int unsigned AW        = 8;
    localparam int unsigned DW        = 8;
    localparam int unsigned START_CYC = 2;
    localparam logic [15:0] MAX_CYC   = 16'd20;
    localparam int          Budget    = 400;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Go = 1'b0;
    logic [AW-1:0] PreloadLen = '0;
    logic [DW-1:0] InData = '0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic          MemWrEn;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWrData;
    logic          Start;
    logic          Ack = 1'b0;
    logic          Busy;
    logic          Done;
    logic          TimedOut;
    logic [15:0]   Cycles;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] validPat = '0;
    int          validPatLen = 0;
    bit          fixedData = 1'b0;

    run_sequencer #(
        .AW        (AW),
        .DW        (DW),
        .START_CYC (START_CYC),
        .MAX_CYC   (MAX_CYC)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Go         (Go),
        .PreloadLen (PreloadLen),
        .InData     (InData),
        .InValid    (InValid),
        .InReady    (InReady),
        .MemWrEn    (MemWrEn),
        .MemAddr    (MemAddr),
        .MemWrData  (MemWrData),
        .Start      (Start),
        .Ack        (Ack),
        .Busy       (Busy),
        .Done       (Done),
        .TimedOut   (TimedOut),
        .Cycles     (Cycles)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One complete run from Go to the IDLE cycle after Done. ackAt is the 1-based RUN
    // cycle in which Ack is first high (0 = never).
    task automatic doRun(input int len, input int ackAt, input bit ackEarly, input int validPct);
        logic [AW+DW-1:0] expW[$];
        int pushes = 0, wrSeen = 0, readyCyc = 0, stalls = 0;
        int startHigh = 0, runCnt = 0, doneCnt = 0;
        int cyc = 0, ackCyc = -1, doneCyc = -1;
        bit seenStart = 1'b0, finished = 1'b0, expTo;
        int expCycles, expRun;

        expTo     = (ackAt == 0) || (ackAt > int'(MAX_CYC) + 1);
        expCycles = expTo ? int'(MAX_CYC) : ackAt - 1;
        expRun    = expTo ? int'(MAX_CYC) + 1 : ackAt;

        PreloadLen = AW'(len);
        Go         = 1'b1;
        Ack        = ackEarly;
        step();
        Go         = 1'b0;
        PreloadLen = AW'($urandom);
        check("busy_after_go", Busy, 1);
        check("first_state", {InReady, Start}, (len != 0) ? 2'b10 : 2'b01);
        check("go_clears", {TimedOut, Cycles}, 0);

        while (!finished) begin
            if (MemWrEn) begin
                wrSeen++;
                if (expW.size() != 0) check("write", {MemAddr, MemWrData}, expW.pop_front());
            end else begin
                check("mem_quiet", {MemAddr, MemWrData}, 0);
            end
            if (Start) begin
                startHigh++;
                seenStart = 1'b1;
            end
            if (Done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (Busy && seenStart && !Start && !Done && !InReady) begin
                runCnt++;
                if (runCnt == ackAt) begin
                    Ack    = 1'b1;
                    ackCyc = cyc;
                end
            end

            if (!Busy) begin
                finished = 1'b1;
            end else begin
                if (InReady) begin
                    readyCyc++;
                    if (validPatLen > 0)
                        InValid = (readyCyc <= validPatLen) ? validPat[readyCyc-1] : 1'b1;
                    else
                        InValid = ($urandom_range(99) < validPct);
                    InData = fixedData ? DW'((pushes + 1) * 17) : DW'($urandom);
                    if (InValid) begin
                        expW.push_back({AW'(pushes), InData});
                        pushes++;
                    end else begin
                        stalls++;
                    end
                end else begin
                    InValid = 1'b0;
                    InData  = DW'($urandom);
                end
                cyc++;
                if (cyc > Budget) begin
                    check("run_budget", cyc, Budget);
                    finished = 1'b1;
                end else begin
                    step();
                end
            end
        end

        Ack     = 1'b0;
        InValid = 1'b0;
        check("accepted_words", pushes, len);
        check("load_cycles", readyCyc, len + stalls);
        check("write_count", wrSeen, len);
        check("start_cycles", startHigh, START_CYC);
        check("run_cycles", runCnt, expRun);
        check("done_count", doneCnt, 1);
        check("idle_after_done", cyc - doneCyc, 1);
        if (!expTo) check("done_latency", doneCyc - ackCyc, 1);
        check("cycles", Cycles, expCycles);
        check("timed_out", TimedOut, expTo);
    endtask

    initial begin
        int n, nGo;

        // Reset and idle
        step();
        check("reset_ctrl", {InReady, MemWrEn, Start, Busy, Done, TimedOut}, 0);
        step();
        check("reset_data", {MemAddr, MemWrData, Cycles}, 0);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_ctrl", {InReady, MemWrEn, Start, Busy, Done, TimedOut}, 0);
            check("idle_data", {MemAddr, MemWrData, Cycles}, 0);
        end

        // Reset and Go together: Reset wins
        Reset = 1'b1;
        Go    = 1'b1;
        PreloadLen = 8'd3;
        step();
        Reset = 1'b0;
        Go    = 1'b0;
        check("reset_beats_go", {Busy, InReady, Start}, 0);

        // Preload 4 fixed words, Ack on 10th RUN cycle
        fixedData = 1'b1;
        doRun(4, 10, 1'b0, 100);
        fixedData = 1'b0;

        // Stalled preload, valid pattern 1,0,0,1,1
        validPat    = 32'b11001;
        validPatLen = 5;
        doRun(3, 3, 1'b0, 100);
        validPatLen = 0;

        // Skip preload, Ack held high throughout
        doRun(0, 1, 1'b1, 100);

        // Timeout, then a follow-up run that must clear TimedOut/Cycles
        doRun(2, 0, 1'b0, 100);
        doRun(1, 5, 1'b0, 100);

        // Boundary: Ack exactly at the limit wins; one cycle later times out
        doRun(0, int'(MAX_CYC) + 1, 1'b0, 100);
        doRun(0, int'(MAX_CYC) + 2, 1'b0, 100);

        for (int r = 0; r < 12; r++) begin
            doRun(int'($urandom_range(6)), int'($urandom_range(24)), 1'b0,
                  int'($urandom_range(100, 30)));
        end

        // Go while running is ignored; Reset mid-run aborts without Done
        PreloadLen = '0;
        Go = 1'b1;
        step();
        Go  = 1'b0;
        n   = 0;
        nGo = -1;
        while (!(Busy && !Start && !Done && Cycles == 16'd5) && n < Budget) begin
            if (Busy && !Start && Cycles == 16'd2 && nGo < 0) begin
                Go  = 1'b1;
                nGo = n;
            end else begin
                Go = 1'b0;
            end
            step();
            n++;
        end
        Go = 1'b0;
        check("reached_cycles5", Cycles, 5);
        check("go_ignored", n - nGo, 3);
        check("still_running", {Busy, Start, InReady, Done}, 4'b1000);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("reset_midrun_ctrl", {Start, Busy, Done, TimedOut, MemWrEn, InReady}, 0);
        check("reset_midrun_cycles", Cycles, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_done_after_reset", {Done, Busy}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
